fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 102 ++++++++++
 tb/tb_fetch_stage.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, instruction-memory handshake,
// one-entry skid buffer for responses that arrive while decode is stalled,
// and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic [31:0] redirect_pc_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic [31:0] imem_rdata_in,
  input  logic        imem_ready_in,
  output logic [31:0] if_id_instr_out,
  output logic [31:0] if_id_pc_out,
  output logic [31:0] if_id_pc_plus4_out,
  output logic        if_id_valid_out
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic [31:0] r_instr;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc4;
  logic        r_valid;

  logic        w_accept;
  logic [31:0] w_pc_plus4;

  // Request only from FETCH; reset masks it so nothing issues before PC is known.
  assign imem_req_out  = (r_state == FETCH) && !rst;
  assign imem_addr_out = r_pc;
  assign w_accept      = imem_req_out && imem_ready_in;
  assign w_pc_plus4    = r_pc + 32'd4;

  assign if_id_instr_out    = r_instr;
  assign if_id_pc_out       = r_id_pc;
  assign if_id_pc_plus4_out = r_id_pc4;
  assign if_id_valid_out    = r_valid;

  // FETCH/HOLD state machine with PC, skid buffer and IF/ID register.
  // Priority: reset, then flush, then stall/response handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_instr      <= NOP_INSTR;
      r_id_pc      <= 32'd0;
      r_id_pc4     <= 32'd4;
      r_valid      <= 1'b0;
    end else if (flush_in) begin
      // Redirect wins over stall and drops any response in this cycle.
      r_state      <= FETCH;
      r_pc         <= {redirect_pc_in[31:2], 2'b00};
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_instr      <= NOP_INSTR;
      r_valid      <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_accept && !stall_in) begin
            r_instr  <= imem_rdata_in;
            r_id_pc  <= r_pc;
            r_id_pc4 <= w_pc_plus4;
            r_valid  <= 1'b1;
            r_pc     <= w_pc_plus4;
          end else if (w_accept) begin
            // Decode is stalled: park the word so it is not lost.
            r_skid_instr <= imem_rdata_in;
            r_skid_pc    <= r_pc;
            r_state      <= HOLD;
          end else if (!stall_in) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall_in) begin
            r_instr  <= r_skid_instr;
            r_id_pc  <= r_skid_pc;
            r_id_pc4 <= r_skid_pc + 32'd4;
            r_valid  <= 1'b1;
            r_pc     <= w_pc_plus4;
            r_state  <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by a
// randomized phase, all compared against a behavioural model of the stage.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall_in, flush_in, imem_ready_in;
  logic [31:0] redirect_pc_in, imem_rdata_in;
  logic        imem_req_out, if_id_valid_out;
  logic [31:0] imem_addr_out, if_id_instr_out, if_id_pc_out, if_id_pc_plus4_out;

  fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
    .redirect_pc_in(redirect_pc_in), .imem_req_out(imem_req_out),
    .imem_addr_out(imem_addr_out), .imem_rdata_in(imem_rdata_in),
    .imem_ready_in(imem_ready_in), .if_id_instr_out(if_id_instr_out),
    .if_id_pc_out(if_id_pc_out), .if_id_pc_plus4_out(if_id_pc_plus4_out),
    .if_id_valid_out(if_id_valid_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: fetch PC, whether a parked word is waiting, and the decode slot.
  logic [31:0] m_pc, m_park_word, m_park_pc, m_instr, m_ipc;
  logic        m_parked, m_valid, m_pc_known;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic f,
                       input logic [31:0] rp, input logic [31:0] rd, input logic rdy);
    rst = r; stall_in = s; flush_in = f; redirect_pc_in = rp;
    imem_rdata_in = rd; imem_ready_in = rdy;
  endtask

  // One clock: check request side, advance the model, check the decode side.
  task automatic cyc;
    #1;
    chk("req", {31'd0, imem_req_out}, {31'd0, !rst && !m_parked});
    if (!rst) chk("addr", imem_addr_out, m_pc);
    if (rst) begin
      m_pc = RPC; m_parked = 1'b0; m_instr = NOP; m_valid = 1'b0;
      m_ipc = 32'd0; m_pc_known = 1'b1;
    end else if (flush_in) begin
      m_pc = redirect_pc_in & 32'hFFFF_FFFC; m_parked = 1'b0;
      m_instr = NOP; m_valid = 1'b0; m_pc_known = 1'b0;
    end else if (m_parked) begin
      if (!stall_in) begin
        m_instr = m_park_word; m_ipc = m_park_pc; m_valid = 1'b1;
        m_pc_known = 1'b1; m_pc = m_pc + 32'd4; m_parked = 1'b0;
      end
    end else if (imem_ready_in && !stall_in) begin
      m_instr = imem_rdata_in; m_ipc = m_pc; m_valid = 1'b1;
      m_pc_known = 1'b1; m_pc = m_pc + 32'd4;
    end else if (imem_ready_in) begin
      m_park_word = imem_rdata_in; m_park_pc = m_pc; m_parked = 1'b1;
    end else if (!stall_in) begin
      m_instr = NOP; m_valid = 1'b0; m_pc_known = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("instr", if_id_instr_out, m_instr);
    chk("valid", {31'd0, if_id_valid_out}, {31'd0, m_valid});
    if (m_pc_known) begin
      chk("id_pc", if_id_pc_out, m_ipc);
      chk("id_pc4", if_id_pc_plus4_out, m_ipc + 32'd4);
    end
  endtask

  initial begin
    m_pc = RPC; m_parked = 1'b0; m_park_word = '0; m_park_pc = '0;
    m_instr = NOP; m_ipc = '0; m_valid = 1'b0; m_pc_known = 1'b0;

    // Reset, second cycle with flush and stall also asserted.
    drive(1, 0, 0, 0, 0, 0); cyc;
    drive(1, 1, 1, 32'h40, 32'h1234, 1); cyc;
    chk("rst_instr", if_id_instr_out, NOP);
    chk("rst_pc", if_id_pc_out, 32'd0);
    chk("rst_pc4", if_id_pc_plus4_out, 32'd4);

    // Back-to-back fetches.
    drive(0, 0, 0, 0, 32'hFFF30293, 1); cyc;
    chk("d0_instr", if_id_instr_out, 32'hFFF30293);
    chk("d0_addr", imem_addr_out, 32'd4);
    drive(0, 0, 0, 0, 32'hFE20AE23, 1); cyc;
    chk("d1_pc", if_id_pc_out, 32'd4);
    chk("d1_addr", imem_addr_out, 32'd8);

    // Memory not ready for three cycles: bubbles, address held.
    repeat (3) begin
      drive(0, 0, 0, 0, 32'hBAD0BAD0, 0); cyc;
      chk("wait_addr", imem_addr_out, 32'd8);
    end

    // Accept at PC 8 under stall, hold one more stalled cycle, then release.
    drive(0, 1, 0, 0, 32'h00A00513, 1); cyc;
    chk("hold_req", {31'd0, imem_req_out}, 32'd0);
    drive(0, 1, 0, 0, 32'h77777777, 1); cyc;
    chk("hold_valid", {31'd0, if_id_valid_out}, 32'd0);
    drive(0, 0, 0, 0, 32'h88888888, 0); cyc;
    chk("rel_instr", if_id_instr_out, 32'h00A00513);
    chk("rel_pc", if_id_pc_out, 32'd8);
    chk("rel_addr", imem_addr_out, 32'd12);

    // Flush with concurrent ready and stall: address aligned, response dropped.
    drive(0, 1, 1, 32'h0000_0103, 32'hDEADBEEF, 1); cyc;
    chk("fl_addr", imem_addr_out, 32'h0000_0100);
    chk("fl_instr", if_id_instr_out, NOP);

    // Flush to the top of the address space and fetch across the wrap.
    drive(0, 0, 1, 32'hFFFF_FFFC, 32'h0, 1); cyc;
    drive(0, 0, 0, 0, 32'h11111111, 1); cyc;
    chk("wrap_pc", if_id_pc_out, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_id_pc_plus4_out, 32'd0);
    chk("wrap_addr", imem_addr_out, 32'd0);

    // Reset while a word is parked: it must never reach decode.
    drive(0, 1, 0, 0, 32'h55555555, 1); cyc;
    drive(1, 1, 0, 0, 32'h0, 0); cyc;
    chk("rh_valid", {31'd0, if_id_valid_out}, 32'd0);
    drive(0, 0, 0, 0, 32'h0, 0); cyc;
    chk("rh_instr", if_id_instr_out, NOP);
    chk("rh_addr", imem_addr_out, RPC);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 9) == 0), $urandom, $urandom,
            ($urandom_range(0, 9) < 6));
      cyc;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
